// File: rtl/qa_drv_fifo_to_host.sv
// rtl/qa_drv_fifo_to_host.sv - packs outbound UMF chunks into cache lines for the FPGA-to-host ring
// Optional idle flush of partial lines: define QA_DRV_FIFO_TO_HOST_IDLE_FLUSH_EN.
module qa_drv_fifo_to_host #(
  parameter int UMF_WIDTH         = 128,
  parameter int LINE_WIDTH        = 512,
  parameter int N_RING_IDX_BITS   = 13,
  parameter int MAX_OUTSTANDING   = 32,
  parameter int IDLE_FLUSH_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic [UMF_WIDTH-1:0]       tx_data,
  input  logic                       tx_eom,
  input  logic                       tx_enable,
  output logic                       tx_rdy,
  input  logic [57:0]                buffer_base_addr,
  output logic                       wr_req,
  output logic [57:0]                wr_addr,
  output logic [LINE_WIDTH-1:0]      wr_data,
  input  logic                       wr_grant,
  input  logic                       wr_ack,
  input  logic [N_RING_IDX_BITS-1:0] oldest_consumed_idx,
  output logic [N_RING_IDX_BITS-1:0] newest_write_line_idx
);

  localparam int CPL   = LINE_WIDTH / UMF_WIDTH;
  localparam int S_W   = $clog2(CPL);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [S_W-1:0]   LAST_SLOT = S_W'(CPL - 1);
  localparam logic [OUT_W-1:0] MAX_OUT   = OUT_W'(MAX_OUTSTANDING);

  if (CPL < 2 || (LINE_WIDTH % UMF_WIDTH) != 0 || UMF_WIDTH < 17 ||
      MAX_OUTSTANDING < 1 || IDLE_FLUSH_CYCLES < 1) begin : g_bad_cfg
    $error("qa_drv_fifo_to_host: unsupported parameter combination");
  end

  typedef enum logic {FILL, REQ} state_t;

  state_t                        state;
  logic [S_W-1:0]                s;
  logic [S_W-1:0]                s_inc;
  logic [CPL-1:0][UMF_WIDTH-1:0] line_q;
  logic [N_RING_IDX_BITS-1:0]    next_idx;
  logic [N_RING_IDX_BITS-1:0]    next_idx_inc;
  logic [OUT_W-1:0]              outstanding;
  logic [OUT_W-1:0]              out_next;
  logic                          sc_full;
  logic                          ring_full;
  logic                          accept;
  logic                          granted;
  logic                          acked;
  logic                          close_line;

  function automatic logic [UMF_WIDTH-1:0] make_hdr(input logic [S_W-1:0] n, input logic eom);
    make_hdr        = '0;
    make_hdr[15:0]  = 16'(n);
    make_hdr[16]    = eom;
  endfunction

  assign s_inc        = s + 1'b1;
  assign next_idx_inc = next_idx + 1'b1;
  assign sc_full      = (state == FILL) && (s == LAST_SLOT);
  // One ring slot always stays empty so full and empty are distinguishable.
  assign ring_full    = (next_idx_inc == oldest_consumed_idx);
  assign tx_rdy       = resetb && (state == FILL) && !sc_full;
  assign wr_req       = resetb && (state == REQ) && !ring_full && (outstanding < MAX_OUT);
  assign accept       = tx_enable && tx_rdy;
  assign granted      = wr_grant && wr_req;
  assign acked        = wr_ack && (outstanding != '0);
  assign close_line   = (s_inc == LAST_SLOT) || tx_eom;
  assign wr_addr      = buffer_base_addr + 58'(next_idx);
  assign wr_data      = line_q;

  always_comb begin
    out_next = outstanding;
    if (granted && !acked)      out_next = outstanding + 1'b1;
    else if (!granted && acked) out_next = outstanding - 1'b1;
  end

`ifdef QA_DRV_FIFO_TO_HOST_IDLE_FLUSH_EN
  localparam int IDLE_W = $clog2(IDLE_FLUSH_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_FLUSH_CYCLES);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_flush;

  assign idle_flush = (state == FILL) && (s != '0) && (idle_cnt == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (!resetb || accept || granted) idle_cnt <= '0;
    else if (state == FILL && s != '0 && idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic idle_flush;
  assign idle_flush = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state                 <= FILL;
      s                     <= '0;
      line_q                <= '0;
      next_idx              <= '0;
      outstanding           <= '0;
      newest_write_line_idx <= '0;
    end else begin
      outstanding <= out_next;
      // Commit point only advances once every granted line has been acknowledged.
      if (out_next == '0) newest_write_line_idx <= next_idx;
      case (state)
        FILL: begin
          if (accept) begin
            line_q[s_inc] <= tx_data;
            s             <= s_inc;
            if (close_line) begin
              line_q[0] <= make_hdr(s_inc, tx_eom);
              state     <= REQ;
            end
          end else if (idle_flush) begin
            line_q[0] <= make_hdr(s, 1'b0);
            state     <= REQ;
          end
        end
        REQ: begin
          if (granted) begin
            next_idx <= next_idx_inc;
            line_q   <= '0;
            s        <= '0;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  a_tx_enable_when_ready: assert property (@(posedge clk) disable iff (!resetb) tx_enable |-> tx_rdy)
    else $fatal(1, "qa_drv_fifo_to_host: tx_enable while tx_rdy is low");
  a_grant_with_req: assert property (@(posedge clk) disable iff (!resetb) wr_grant |-> wr_req)
    else $fatal(1, "qa_drv_fifo_to_host: wr_grant without wr_req");
  a_ack_with_outstanding: assert property (@(posedge clk) disable iff (!resetb) wr_ack |-> (outstanding != '0))
    else $fatal(1, "qa_drv_fifo_to_host: wr_ack with nothing outstanding");

endmodule

// File: tb/tb_qa_drv_fifo_to_host.sv
// tb/tb_qa_drv_fifo_to_host.sv - scoreboard bench for qa_drv_fifo_to_host
// Idle-flush expectations follow QA_DRV_FIFO_TO_HOST_IDLE_FLUSH_EN.
module tb_qa_drv_fifo_to_host;

  localparam int UMF_W  = 128;
  localparam int LINE_W = 512;
  localparam int CPL    = LINE_W / UMF_W;
  localparam int IDX_W  = 13;

  typedef struct {
    logic [57:0]       addr;
    logic [LINE_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic [UMF_W-1:0]  tx_data = '0;
  logic              tx_eom = 1'b0;
  logic              tx_enable = 1'b0;
  logic              tx_rdy;
  logic [57:0]       buffer_base_addr = 58'h0AB_CDEF_0007;
  logic              wr_req;
  logic [57:0]       wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic              wr_grant = 1'b0;
  logic              wr_ack = 1'b0;
  logic [IDX_W-1:0]  oldest_consumed_idx = '0;
  logic [IDX_W-1:0]  newest_write_line_idx;

  int n_vec = 0;
  int n_err = 0;

  wr_t              exp_q[$];
  logic [IDX_W-1:0] push_idx = '0;
  logic [IDX_W-1:0] gidx = '0;
  logic [IDX_W-1:0] exp_newest = '0;
  int               pend = 0;
  int               ack_credit = 1000000;
  bit               ack_on_grant = 1'b0;

  qa_drv_fifo_to_host dut (
    .clk                   (clk),
    .resetb                (resetb),
    .tx_data               (tx_data),
    .tx_eom                (tx_eom),
    .tx_enable             (tx_enable),
    .tx_rdy                (tx_rdy),
    .buffer_base_addr      (buffer_base_addr),
    .wr_req                (wr_req),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .wr_grant              (wr_grant),
    .wr_ack                (wr_ack),
    .oldest_consumed_idx   (oldest_consumed_idx),
    .newest_write_line_idx (newest_write_line_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [UMF_W-1:0] rnd_chunk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_line(input logic [LINE_W-1:0] line);
    wr_t w;
    w.addr = buffer_base_addr + 58'(push_idx);
    w.data = line;
    exp_q.push_back(w);
    push_idx++;
  endtask

  task automatic send_chunk(input logic [UMF_W-1:0] d, input logic eom);
    int t = 0;
    while (!tx_rdy && t < 5000) begin @(negedge clk); t++; end
    if (!tx_rdy) begin
      chk("tx_rdy_timeout", 0, 1);
      return;
    end
    tx_data = d; tx_eom = eom; tx_enable = 1'b1;
    @(negedge clk);
    tx_enable = 1'b0; tx_eom = 1'b0;
  endtask

  // Expected lines are built chunk by chunk from the line format, then the chunk is driven.
  task automatic send_msg(input int n, input bit eom_last);
    logic [LINE_W-1:0] line = '0;
    logic [UMF_W-1:0]  d;
    int  k = 0;
    bit  last;
    for (int i = 0; i < n; i++) begin
      d = rnd_chunk();
      k++;
      line[k*UMF_W +: UMF_W] = d;
      last = (i == n - 1) && eom_last;
      if (k == CPL - 1 || last) begin
        line[15:0] = 16'(k);
        line[16]   = last;
        push_line(line);
        line = '0;
        k = 0;
      end
      send_chunk(d, last);
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    chk(tag, exp_q.size() == 0, 1);
  endtask

  task automatic wait_pend(input string tag, input int target);
    int t = 0;
    while (pend != target && t < 3000) begin @(negedge clk); t++; end
    chk(tag, pend == target, 1);
  endtask

  // Host side: grants every request, acks per credit, checks writes and the commit pointer.
  initial begin
    bit g, a;
    wr_t w;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        wr_grant = 1'b0; wr_ack = 1'b0;
      end else begin
        chk("newest_idx", newest_write_line_idx, exp_newest);
        g = wr_req;
        a = (ack_credit > 0) && (pend > 0) && (!ack_on_grant || g);
        if (g) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 0, 1);
          end else begin
            w = exp_q.pop_front();
            chk("wr_addr", wr_addr, w.addr);
            chk("wr_data", wr_data, w.data);
          end
        end
        wr_grant = g;
        wr_ack = a;
        if (a) ack_credit--;
        pend = pend + int'(g) - int'(a);
        if (pend == 0) exp_newest = gidx;
        if (g) gidx++;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] line;
    logic [UMF_W-1:0]  d1, d2;
    logic [IDX_W-1:0]  held;
    int busy;

    repeat (3) @(negedge clk);
    chk("reset_tx_rdy", tx_rdy, 0);
    chk("reset_wr_req", wr_req, 0);
    chk("reset_newest", newest_write_line_idx, 0);
    resetb = 1'b1;
    @(negedge clk);
    chk("post_reset_tx_rdy", tx_rdy, 1);

    // Three chunks ending in EOM fill one line exactly.
    line = '0;
    line[15:0] = 16'd3;
    line[16] = 1'b1;
    line[1*UMF_W +: UMF_W] = 128'hA;
    line[2*UMF_W +: UMF_W] = 128'hB;
    line[3*UMF_W +: UMF_W] = 128'hC;
    push_line(line);
    send_chunk(128'hA, 1'b0);
    send_chunk(128'hB, 1'b0);
    send_chunk(128'hC, 1'b1);
    chk("latency_wr_req", wr_req, 1);
    wait_drain("t1_drain");
    wait_pend("t1_ack", 0);
    repeat (2) @(negedge clk);
    chk("t1_newest", newest_write_line_idx, 1);

    send_msg(7, 1'b1);
    wait_drain("t2_drain");
    wait_pend("t2_ack", 0);

    // Commit pointer holds until every outstanding write is acknowledged.
    ack_credit = 0;
    repeat (2) @(negedge clk);
    held = newest_write_line_idx;
    for (int i = 0; i < 4; i++) send_msg(1, 1'b1);
    wait_drain("t3_drain");
    ack_credit = 3;
    wait_pend("t3_ack3", 1);
    repeat (3) @(negedge clk);
    chk("t3_newest_hold", newest_write_line_idx, held);
    ack_on_grant = 1'b1;
    ack_credit = 1;
    send_msg(1, 1'b1);
    wait_drain("t3_simul_drain");
    repeat (3) @(negedge clk);
    chk("t3_simul_pend", pend, 1);
    chk("t3_simul_newest", newest_write_line_idx, held);
    ack_on_grant = 1'b0;
    ack_credit = 1;
    wait_pend("t3_last_ack", 0);
    repeat (2) @(negedge clk);
    chk("t3_newest_adv", newest_write_line_idx, held + 13'd5);
    ack_credit = 1000000;

    // Fill the ring up to the one-empty-slot limit, then release and wrap.
    while (push_idx != 13'h1FFF) send_msg(1, 1'b1);
    wait_drain("ring_fill_drain");
    send_msg(1, 1'b1);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_req || tx_rdy) busy++;
    end
    chk("ring_full_hold", busy, 0);
    chk("ring_full_pending", exp_q.size(), 1);
    oldest_consumed_idx = 13'd5;
    wait_drain("ring_last_slot");
    send_msg(1, 1'b1);
    wait_drain("ring_wrap");
    oldest_consumed_idx = 13'd4000;
    wait_pend("ring_ack", 0);

    // Outstanding limit.
    ack_credit = 0;
    for (int i = 0; i < 32; i++) send_msg(1, 1'b1);
    wait_drain("max_out_drain");
    send_msg(1, 1'b1);
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_req) busy++;
    end
    chk("max_out_hold", busy, 0);
    ack_credit = 1;
    wait_drain("max_out_release");
    ack_credit = 1000000;
    wait_pend("max_out_ack", 0);
    repeat (2) @(negedge clk);
    chk("max_out_newest", newest_write_line_idx, push_idx);

    // Partial line with no EOM.
    d1 = rnd_chunk();
`ifdef QA_DRV_FIFO_TO_HOST_IDLE_FLUSH_EN
    line = '0;
    line[15:0] = 16'd1;
    line[1*UMF_W +: UMF_W] = d1;
    push_line(line);
    send_chunk(d1, 1'b0);
    wait_drain("idle_flush");
`else
    send_chunk(d1, 1'b0);
    busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (wr_req) busy++;
    end
    chk("no_idle_flush", busy, 0);
    d2 = rnd_chunk();
    line = '0;
    line[15:0] = 16'd2;
    line[16] = 1'b1;
    line[1*UMF_W +: UMF_W] = d1;
    line[2*UMF_W +: UMF_W] = d2;
    push_line(line);
    send_chunk(d2, 1'b1);
    wait_drain("partial_eom");
`endif
    wait_pend("final_ack", 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
